// File: rtl/glitch_cmd_rx.sv
// UART 8N1 command receiver: parses A5/CMD/DHI/DLO/WID/CHK frames into glitch delay and width.
// Outputs update 1 clk after the CHK stop-bit sample; no backpressure, the line is consumed at bit rate.
module glitch_cmd_rx #(
   parameter int CLKS_PER_BIT = 104,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        din,
   output logic        glitch_en,
   output logic [15:0] delay_out,
   output logic [7:0]  width_out,
   output logic        frame_err
);
   localparam int HALF_BIT = CLKS_PER_BIT / 2;
   localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int BCW      = $clog2(CLKS_PER_BIT + 1);
   localparam int TOW      = $clog2(TO_LIMIT + 1);
   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam logic [7:0] CMD_SET   = 8'h53;
   localparam logic [7:0] CMD_FIRE  = 8'h47;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {P_HUNT, P_CMD, P_DHI, P_DLO, P_WID, P_CHK} parse_state_t;

   logic           din_meta, din_sync;
   rx_state_t      rx_state, rx_next;
   logic [BCW-1:0] bit_cnt, bit_cnt_next;
   logic [2:0]     bit_idx, bit_idx_next;
   logic [7:0]     shift, shift_next;
   logic           byte_valid, stop_err;

   parse_state_t   p_state, p_next;
   logic [7:0]     cmd_q, dhi_q, dlo_q, wid_q;
   logic [7:0]     cmd_next, dhi_next, dlo_next, wid_next;
   logic [7:0]     chk_calc;
   logic [TOW-1:0] to_cnt, to_cnt_next;
   logic           timeout;
   logic           glitch_next, ferr_next;
   logic [15:0]    delay_next;
   logic [7:0]     width_next;

   // UART receive: start bit verified at half-bit, then full-bit spacing
   always_comb begin
      rx_next      = rx_state;
      bit_cnt_next = bit_cnt + BCW'(1);
      bit_idx_next = bit_idx;
      shift_next   = shift;
      byte_valid   = 1'b0;
      stop_err     = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            bit_cnt_next = '0;
            if (!din_sync) rx_next = RX_START;
         end
         RX_START: begin
            if (bit_cnt == BCW'(HALF_BIT - 1)) begin
               bit_cnt_next = '0;
               bit_idx_next = 3'd0;
               rx_next      = din_sync ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (bit_cnt == BCW'(CLKS_PER_BIT - 1)) begin
               bit_cnt_next = '0;
               shift_next   = {din_sync, shift[7:1]};
               bit_idx_next = bit_idx + 3'd1;
               if (bit_idx == 3'd7) rx_next = RX_STOP;
            end
         end
         RX_STOP: begin
            if (bit_cnt == BCW'(CLKS_PER_BIT - 1)) begin
               bit_cnt_next = '0;
               rx_next      = RX_IDLE;
               byte_valid   = din_sync;
               stop_err     = !din_sync;
            end
         end
         default: rx_next = RX_IDLE;
      endcase
   end

   assign chk_calc = cmd_q ^ dhi_q ^ dlo_q ^ wid_q;
   assign timeout  = (p_state != P_HUNT) && (rx_state == RX_IDLE) &&
                     (to_cnt == TOW'(TO_LIMIT - 1));

   // Frame parser; byte events and timeout are mutually exclusive (timeout needs RX idle)
   always_comb begin
      p_next      = p_state;
      cmd_next    = cmd_q;
      dhi_next    = dhi_q;
      dlo_next    = dlo_q;
      wid_next    = wid_q;
      delay_next  = delay_out;
      width_next  = width_out;
      glitch_next = 1'b0;
      ferr_next   = 1'b0;
      if (stop_err) begin
         p_next    = P_HUNT;
         ferr_next = 1'b1;
      end else if (byte_valid) begin
         case (p_state)
            P_HUNT: if (shift == SYNC_BYTE) p_next = P_CMD;
            P_CMD: begin
               if (shift == CMD_SET || shift == CMD_FIRE) begin
                  cmd_next = shift;
                  p_next   = P_DHI;
               end else begin
                  ferr_next = 1'b1;
                  p_next    = P_HUNT;
               end
            end
            P_DHI: begin dhi_next = shift; p_next = P_DLO; end
            P_DLO: begin dlo_next = shift; p_next = P_WID; end
            P_WID: begin wid_next = shift; p_next = P_CHK; end
            P_CHK: begin
               p_next = P_HUNT;
               if (shift == chk_calc) begin
                  delay_next  = {dhi_q, dlo_q};
                  width_next  = wid_q;
                  glitch_next = (cmd_q == CMD_FIRE);
               end else begin
                  ferr_next = 1'b1;
               end
            end
            default: p_next = P_HUNT;
         endcase
      end else if (timeout) begin
         p_next    = P_HUNT;
         ferr_next = 1'b1;
      end

      to_cnt_next = to_cnt;
      if (p_state == P_HUNT || byte_valid || stop_err || timeout)
         to_cnt_next = '0;
      else if (rx_state == RX_IDLE)
         to_cnt_next = to_cnt + TOW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         din_meta  <= 1'b1;
         din_sync  <= 1'b1;
         rx_state  <= RX_IDLE;
         bit_cnt   <= '0;
         bit_idx   <= 3'd0;
         shift     <= 8'h00;
         p_state   <= P_HUNT;
         cmd_q     <= 8'h00;
         dhi_q     <= 8'h00;
         dlo_q     <= 8'h00;
         wid_q     <= 8'h00;
         to_cnt    <= '0;
         glitch_en <= 1'b0;
         frame_err <= 1'b0;
         delay_out <= 16'h0000;
         width_out <= 8'h00;
      end else begin
         din_meta  <= din;
         din_sync  <= din_meta;
         rx_state  <= rx_next;
         bit_cnt   <= bit_cnt_next;
         bit_idx   <= bit_idx_next;
         shift     <= shift_next;
         p_state   <= p_next;
         cmd_q     <= cmd_next;
         dhi_q     <= dhi_next;
         dlo_q     <= dlo_next;
         wid_q     <= wid_next;
         to_cnt    <= to_cnt_next;
         glitch_en <= glitch_next;
         frame_err <= ferr_next;
         delay_out <= delay_next;
         width_out <= width_next;
      end
   end
endmodule

// File: tb/tb_glitch_cmd_rx.sv
// Randomized + directed bench for glitch_cmd_rx against a byte-level frame model.
module tb_glitch_cmd_rx;
   localparam int CPB   = 16;
   localparam int TOB   = 20;
   localparam int LIMIT = CPB * TOB;

   logic        clk = 1'b0;
   logic        rst;
   logic        din;
   logic        glitch_en;
   logic [15:0] delay_out;
   logic [7:0]  width_out;
   logic        frame_err;

   glitch_cmd_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
      .clk(clk), .rst(rst), .din(din), .glitch_en(glitch_en),
      .delay_out(delay_out), .width_out(width_out), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Output pulse monitor
   int   g_cnt = 0, f_cnt = 0, g_hi = 0, f_hi = 0;
   int   g_rise = -1, f_rise = -1;
   logic g_prev = 1'b0, f_prev = 1'b0;
   always @(negedge clk) begin
      if (glitch_en === 1'b1) begin
         g_hi++;
         if (!g_prev) begin g_cnt++; g_rise = cyc; end
      end
      if (frame_err === 1'b1) begin
         f_hi++;
         if (!f_prev) begin f_cnt++; f_rise = cyc; end
      end
      if (glitch_en === 1'b1 || frame_err === 1'b1)
         check("exclusive", {31'b0, glitch_en & frame_err}, 32'd0);
      g_prev = (glitch_en === 1'b1);
      f_prev = (frame_err === 1'b1);
   end

   // Byte-level reference: position within frame plus captured fields
   int          m_pos = 0;
   logic [7:0]  m_buf [1:5];
   logic [15:0] m_delay = 16'h0000;
   logic [7:0]  m_width = 8'h00;
   int          m_g = 0, m_f = 0;

   task automatic model_byte(input logic [7:0] b, input bit ok);
      if (!ok) begin
         m_f++;
         m_pos = 0;
      end else if (m_pos == 0) begin
         if (b == 8'hA5) m_pos = 1;
      end else if (m_pos == 1) begin
         if (b == 8'h53 || b == 8'h47) begin m_buf[1] = b; m_pos = 2; end
         else begin m_f++; m_pos = 0; end
      end else if (m_pos < 5) begin
         m_buf[m_pos] = b;
         m_pos++;
      end else begin
         if (b == (m_buf[1] ^ m_buf[2] ^ m_buf[3] ^ m_buf[4])) begin
            m_delay = {m_buf[2], m_buf[3]};
            m_width = m_buf[4];
            if (m_buf[1] == 8'h47) m_g++;
         end else begin
            m_f++;
         end
         m_pos = 0;
      end
   endtask

   int last_start = 0;

   task automatic drive_bit(input logic v);
      din = v;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic compare_state();
      check("glitch_cnt", g_cnt, m_g);
      check("ferr_cnt", f_cnt, m_f);
      check("delay_out", {16'h0, delay_out}, {16'h0, m_delay});
      check("width_out", {24'h0, width_out}, {24'h0, m_width});
   endtask

   task automatic send_byte(input logic [7:0] b, input bit ok, input int gap_bits);
      last_start = cyc;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(ok);
      din = 1'b1;
      repeat (gap_bits * CPB + 4) @(posedge clk);
      #1;
      model_byte(b, ok);
      if (gap_bits > TOB && m_pos != 0) begin m_f++; m_pos = 0; end
      compare_state();
   endtask

   task automatic send_frame(input logic [7:0] b0, b1, b2, b3, b4, b5);
      send_byte(b0, 1'b1, 0);
      send_byte(b1, 1'b1, 1);
      send_byte(b2, 1'b1, 0);
      send_byte(b3, 1'b1, 2);
      send_byte(b4, 1'b1, 0);
      send_byte(b5, 1'b1, 1);
   endtask

   int         lat;
   logic [7:0] fr [6];
   int         long_idx, bad_idx, r;

   initial begin
      din = 1'b1;
      rst = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("rst_glitch", {31'b0, glitch_en}, 32'd0);
      check("rst_ferr", {31'b0, frame_err}, 32'd0);
      check("rst_delay", {16'h0, delay_out}, 32'd0);
      check("rst_width", {24'h0, width_out}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (CPB) @(posedge clk);
      #1;

      // Fire frame; glitch latency measured from the CHK start bit
      send_frame(8'hA5, 8'h47, 8'h01, 8'hF4, 8'h0A, 8'hB8);
      lat = g_rise - last_start;
      check("lat_window", {31'b0, (lat >= CPB / 2 + 9 * CPB) && (lat <= CPB / 2 + 9 * CPB + 5)}, 32'd1);
      check("g_width_fire", g_hi, 1);

      // Set frame, then bad checksum
      send_frame(8'hA5, 8'h53, 8'h00, 8'h10, 8'h05, 8'h46);
      send_frame(8'hA5, 8'h53, 8'h00, 8'h20, 8'h07, 8'h00);

      // Framing error during WID, then good fire frame
      send_byte(8'hA5, 1'b1, 0);
      send_byte(8'h47, 1'b1, 0);
      send_byte(8'h12, 1'b1, 0);
      send_byte(8'h34, 1'b1, 0);
      send_byte(8'h47, 1'b0, 2);
      send_frame(8'hA5, 8'h47, 8'h12, 8'h34, 8'h56, 8'h37);

      // Timeout after A5 47 01 with a 21-bit gap
      send_byte(8'hA5, 1'b1, 0);
      send_byte(8'h47, 1'b1, 0);
      send_byte(8'h01, 1'b1, TOB + 1);
      check("timeout_at", f_rise - last_start, lat + LIMIT);
      send_frame(8'hA5, 8'h53, 8'hAB, 8'hCD, 8'h0E, 8'h3B);

      // A5 inside a frame is data
      send_frame(8'hA5, 8'h53, 8'hA5, 8'hA5, 8'h01, 8'h52);

      // Quarter-bit low glitch mid-frame must not create a byte
      send_byte(8'hA5, 1'b1, 0);
      send_byte(8'h47, 1'b1, 0);
      send_byte(8'h02, 1'b1, 0);
      send_byte(8'h03, 1'b1, 1);
      din = 1'b0;
      repeat (CPB / 4) @(posedge clk);
      #1;
      din = 1'b1;
      repeat (CPB * 2) @(posedge clk);
      #1;
      compare_state();
      send_byte(8'h04, 1'b1, 0);
      send_byte(8'h40, 1'b1, 1);

      // Reset during DLO byte
      send_byte(8'hA5, 1'b1, 0);
      send_byte(8'h47, 1'b1, 0);
      send_byte(8'h01, 1'b1, 0);
      din = 1'b0;
      repeat (CPB * 3) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("midrst_delay", {16'h0, delay_out}, 32'd0);
      check("midrst_width", {24'h0, width_out}, 32'd0);
      check("midrst_glitch", {31'b0, glitch_en}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      din = 1'b1;
      m_pos = 0; m_delay = 16'h0000; m_width = 8'h00;
      repeat (CPB * 2) @(posedge clk);
      #1;
      send_frame(8'hA5, 8'h47, 8'h01, 8'hF4, 8'h0A, 8'hB8);

      // Randomized frames with stray bytes, bad commands/checksums, stop errors, timeouts
      for (int f = 0; f < 12; f++) begin
         if ($urandom_range(0, 3) == 0) send_byte(8'($urandom), 1'b1, 1);
         r = $urandom_range(0, 9);
         fr[0] = 8'hA5;
         fr[1] = (r < 4) ? 8'h47 : (r < 8) ? 8'h53 : 8'($urandom);
         fr[2] = 8'($urandom);
         fr[3] = 8'($urandom);
         fr[4] = 8'($urandom);
         fr[5] = fr[1] ^ fr[2] ^ fr[3] ^ fr[4];
         if ($urandom_range(0, 4) == 0) fr[5] = fr[5] ^ (8'h01 << $urandom_range(0, 7));
         long_idx = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 4) : -1;
         bad_idx  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 5) : -1;
         for (int i = 0; i < 6; i++) begin
            if (i == bad_idx)
               send_byte(fr[i], 1'b0, 2);
            else if (i == long_idx)
               send_byte(fr[i], 1'b1, TOB + 4);
            else
               send_byte(fr[i], 1'b1, $urandom_range(0, 3));
         end
      end

      check("glitch_cycles", g_hi, m_g);
      check("ferr_cycles", f_hi, m_f);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
